// File: rtl/main_mem_pkg.sv
// Shared types and sizes for the cache backing-store responder.
// Pure declarations: no latency, no backpressure.
package main_mem_pkg;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 32;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/main_mem_array.sv
// 32 x 8 storage, reset to mem[i]=i; synchronous write, combinational read.
// Write lands on the clock edge; read is same-cycle; never stalls.
module main_mem_array
    import main_mem_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= DATA_W'(i);
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/main_memory_ctrl.sv
// Slow main memory behind a req/ack handshake, with saturating debug counters.
// Ack LATENCY cycles after acceptance; busy holds off new requests until the cycle after ack.
module main_memory_ctrl
    import main_mem_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic              i_clock,
    input  logic              i_resetn,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_busy,
    output logic              o_ack,
    output logic [DATA_W-1:0] o_rdata,
    output logic [CNT_W-1:0]  o_rd_count,
    output logic [CNT_W-1:0]  o_wr_count
);
    localparam logic [3:0] LOAD = 4'(LATENCY - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_busy;
    logic                r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic [CNT_W-1:0]    r_rd_count;
    logic [CNT_W-1:0]    r_wr_count;
    logic                w_accept;
    logic                w_cur_we;
    logic [ADDR_W-1:0]   w_raddr;
    logic [DATA_W-1:0]   w_mem_rdata;
    logic                w_mem_we;

    a_latency_range: assert property (@(posedge i_clock) (LATENCY >= 1) && (LATENCY <= 15));

    assign w_accept = (r_state == IDLE) && i_req;
    // With LATENCY=1 RESPOND is entered on the accepting edge, so the live inputs are used.
    assign w_cur_we = (r_state == IDLE) ? i_we   : r_we;
    assign w_raddr  = (r_state == IDLE) ? i_addr : r_addr;
    assign w_mem_we = (r_state == RESPOND) && r_we;

    main_mem_array u_array (
        .i_clk   (i_clock),
        .i_rst_n (i_resetn),
        .i_we    (w_mem_we),
        .i_waddr (r_addr),
        .i_wdata (r_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (i_req) begin
                    w_cnt_nxt   = LOAD;
                    w_state_nxt = (LATENCY == 1) ? RESPOND : WAIT;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = RESPOND;
                end
            end
            RESPOND: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_ack   <= (w_state_nxt == RESPOND);
            if (w_accept) begin
                r_we    <= i_we;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
            // Read data is captured entering RESPOND so it is valid alongside ack.
            if ((w_state_nxt == RESPOND) && !w_cur_we) begin
                r_rdata <= w_mem_rdata;
            end
            if (r_state == RESPOND) begin
                if (r_we) begin
                    r_wr_count <= sat_inc(r_wr_count);
                end else begin
                    r_rd_count <= sat_inc(r_rd_count);
                end
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_ack      = r_ack;
    assign o_rdata    = r_rdata;
    assign o_rd_count = r_rd_count;
    assign o_wr_count = r_wr_count;
endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench: three instances (LATENCY 3, 1, 15) driven one at a time against a memory model.
module tb_main_memory_ctrl;
    localparam int NDUT = 3;
    localparam int LATS [NDUT] = '{3, 1, 15};

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic       req   [NDUT];
    logic       we    [NDUT];
    logic [4:0] addr  [NDUT];
    logic [7:0] wdata [NDUT];
    logic       busy  [NDUT];
    logic       ack   [NDUT];
    logic [7:0] rdata [NDUT];
    logic [7:0] rd_count [NDUT];
    logic [7:0] wr_count [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        main_memory_ctrl #(.LATENCY(LATS[g])) u_dut (
            .i_clock    (clk),
            .i_resetn   (rstn),
            .i_req      (req[g]),
            .i_we       (we[g]),
            .i_addr     (addr[g]),
            .i_wdata    (wdata[g]),
            .o_busy     (busy[g]),
            .o_ack      (ack[g]),
            .o_rdata    (rdata[g]),
            .o_rd_count (rd_count[g]),
            .o_wr_count (wr_count[g])
        );
    end

    typedef struct {
        int         d;
        int         acc;
        logic [7:0] exp_rdata;
        logic [7:0] exp_rd;
        logic [7:0] exp_wr;
    } txn_t;

    txn_t       exp_q [$];
    logic [7:0] m_mem   [NDUT][32];
    logic [7:0] m_rdata [NDUT];
    int         m_rd    [NDUT];
    int         m_wr    [NDUT];
    int         cyc;
    int         checks;
    int         errors;
    txn_t       mh;
    int         mdt;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d actual=%0h required=%0h", name, d, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 32; i++) m_mem[d][i] = 8'(i);
            m_rdata[d] = 8'h00;
            m_rd[d]    = 0;
            m_wr[d]    = 0;
        end
        exp_q.delete();
    endtask

    // Present a request; while the DUT is busy the inputs are scrambled with req high.
    task automatic issue(input int d, input bit w, input logic [4:0] a, input logic [7:0] wd,
                         output int acc);
        int   t;
        txn_t x;
        t   = 0;
        acc = 0;
        @(negedge clk);
        while (busy[d] !== 1'b0 && t < 200) begin
            req[d]   = 1'b1;
            we[d]    = 1'($urandom);
            addr[d]  = 5'($urandom);
            wdata[d] = 8'($urandom);
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout dut=%0d actual=busy required=idle", d);
            return;
        end
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        acc      = cyc;
        x.d      = d;
        x.acc    = cyc;
        x.exp_rd = 8'(m_rd[d]);
        x.exp_wr = 8'(m_wr[d]);
        if (w) begin
            m_mem[d][a] = wd;
            m_wr[d]     = (m_wr[d] < 255) ? m_wr[d] + 1 : 255;
        end else begin
            m_rdata[d] = m_mem[d][a];
            m_rd[d]    = (m_rd[d] < 255) ? m_rd[d] + 1 : 255;
        end
        x.exp_rdata = m_rdata[d];
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        req[d] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        for (int d = 0; d < NDUT; d++) req[d] = 1'b0;
        while (exp_q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            for (int d = 0; d < NDUT; d++) begin
                if (ack[d] === 1'b1 && (exp_q.size() == 0 || exp_q[0].d != d)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack dut=%0d actual=1 required=0", d);
                end
            end
            if (exp_q.size() > 0) begin
                mh  = exp_q[0];
                mdt = cyc - mh.acc;
                if (mdt >= 1 && mdt < LATS[mh.d]) begin
                    chk("busy_in_wait", mh.d, 32'(busy[mh.d]), 32'd1);
                    chk("ack_early", mh.d, 32'(ack[mh.d]), 32'd0);
                end else if (mdt >= LATS[mh.d]) begin
                    chk("ack_latency", mh.d, 32'(ack[mh.d]), 32'd1);
                    chk("busy_in_ack", mh.d, 32'(busy[mh.d]), 32'd1);
                    chk("rdata", mh.d, 32'(rdata[mh.d]), 32'(mh.exp_rdata));
                    chk("rd_count", mh.d, 32'(rd_count[mh.d]), 32'(mh.exp_rd));
                    chk("wr_count", mh.d, 32'(wr_count[mh.d]), 32'(mh.exp_wr));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        rstn = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            req[d]   = 1'b0;
            we[d]    = 1'b0;
            addr[d]  = '0;
            wdata[d] = '0;
        end
        m_reset();
        #3;
        for (int d = 0; d < NDUT; d++) begin
            chk("reset_busy", d, 32'(busy[d]), 32'd0);
            chk("reset_ack", d, 32'(ack[d]), 32'd0);
            chk("reset_rdata", d, 32'(rdata[d]), 32'h00);
            chk("reset_rd_count", d, 32'(rd_count[d]), 32'd0);
            chk("reset_wr_count", d, 32'(wr_count[d]), 32'd0);
        end
        @(negedge clk);
        rstn = 1'b1;

        issue(0, 1'b0, 5'd17, 8'h00, acc);
        idle(0, 2);
        issue(0, 1'b1, 5'd9, 8'hA5, acc);
        idle(0, 1);
        issue(0, 1'b0, 5'd9, 8'h00, acc);
        drain();

        issue(1, 1'b0, 5'($urandom), 8'h00, prev);
        for (int i = 1; i < 4; i++) begin
            issue(1, 1'b0, 5'($urandom), 8'($urandom), acc);
            chk("b2b_spacing", 1, 32'(acc - prev), 32'(LATS[1] + 1));
            prev = acc;
        end
        drain();

        issue(0, 1'b1, 5'd3, 8'h5A, acc);
        @(negedge clk);
        #2;
        rstn   = 1'b0;
        req[0] = 1'b0;
        #1;
        chk("areset_busy", 0, 32'(busy[0]), 32'd0);
        chk("areset_ack", 0, 32'(ack[0]), 32'd0);
        chk("areset_rdata", 0, 32'(rdata[0]), 32'h00);
        chk("areset_rd_count", 0, 32'(rd_count[0]), 32'd0);
        chk("areset_wr_count", 0, 32'(wr_count[0]), 32'd0);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        issue(0, 1'b0, 5'd3, 8'h00, acc);
        drain();

        issue(2, 1'b0, 5'd31, 8'h00, acc);
        drain();

        for (int i = 0; i < 260; i++) begin
            issue(1, 1'b0, 5'($urandom), 8'($urandom), acc);
        end
        drain();
        chk("sat_rd_count", 1, 32'(rd_count[1]), 32'd255);
        chk("sat_wr_count", 1, 32'(wr_count[1]), 32'd0);

        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 30; i++) begin
                issue(d, 1'($urandom), 5'($urandom_range(0, 7)), 8'($urandom), acc);
                if ($urandom_range(0, 1) == 1) idle(d, $urandom_range(1, 3));
            end
            drain();
        end

        for (int d = 0; d < NDUT; d++) begin
            chk("final_rd_count", d, 32'(rd_count[d]), 32'(m_rd[d]));
            chk("final_wr_count", d, 32'(wr_count[d]), 32'(m_wr[d]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
